pool_result_collector: RTL and testbench
========================================

# pool_result_collector

Collects "nonce found" events from a parametrised pool of SHA-256 cores and queues them in a small FIFO. It signals pending results on the shared open-drain ready line and hands them out as fixed-length frames over the daisy-chain SPI port (sck1/sdi1/sdo1/cs1_n). It sits between the pool array and the daisy pins in the top level. It supersedes the single-pool direct readout: it adds multi-pool arbitration, buffering, overflow reporting and daisy pass-through.

## Interface
Parameters:
- POOL_SIZE, 2: number of pool cores feeding results; 1..64.
- POOL_SIZE_LOG2, 1: index width; 0 allowed when POOL_SIZE = 1 (index field then reads 0).
- NONCE_WIDTH, 32: nonce bits per result.
- FIFO_DEPTH_LOG2, 2: FIFO holds 2^FIFO_DEPTH_LOG2 results.
- LED_DIV_LOG2, 22: heartbeat toggles every 2^LED_DIV_LOG2 clk_in cycles.

Ports:
- clk_in  in  1  system clock (post-PLL).
- reset_n_in  in  1  asynchronous, active-low reset.
- found_in  in  POOL_SIZE  per-pool one-cycle success pulse.
- nonce_in  in  POOL_SIZE*NONCE_WIDTH  per-pool nonce; pool i at [i*NONCE_WIDTH +: NONCE_WIDTH]; valid when found_in[i] is high.
- sck1_in  in  1  daisy SPI clock, asynchronous, at most clk_in/8.
- sdi1_in  in  1  daisy data from upstream device.
- cs1_n_in  in  1  daisy chip select, active low.
- sdo1_out  out  1  daisy data to downstream device.
- ready_n_ts_out  out  1  driven 0 while the FIFO is non-empty or overflow is set, otherwise high-Z.
- status_led_n_out  out  1  status LED, active low.

## Operation
- Frame: FRAME_BITS = 8 + NONCE_WIDTH, sent MSB first. Header byte: bit7 valid, bit6 overflow, bits5..0 pool index. The nonce follows.
- Capture: each pool has a one-entry holding register.
  - found_in[i] with the holding register empty: load the nonce and set held[i].
  - found_in[i] with held[i] already set: drop the new nonce, keep the old one, set sticky overflow.
- Arbiter: round-robin over held[]. Each cycle it pushes at most one held entry into the FIFO if the FIFO is not full, then clears that held bit. The grant pointer advances past the granted index.
- FIFO full: holding registers retain their contents and the arbiter stalls. No loss occurs unless a pool fires again.
- SPI inputs: sck1, sdi1 and cs1_n each pass through 2-FF synchronisers. Edges are detected on the synchronised copies.
- cs1_n falling edge:
  - FIFO non-empty: load the shift register with {1, ovf, idx, nonce} from the FIFO head.
  - FIFO empty: load {0, ovf, 6'b0, 0}.
  - Clear the bit counter.
- SPI mode 0:
  - sck1 rising: shift sdi1 into the LSB, increment the bit counter (saturate at FRAME_BITS).
  - sck1 falling: sdo1_out <= shift-register MSB.
  - Upstream frames therefore emerge after FRAME_BITS clocks (daisy pass-through).
- cs1_n rising:
  - Bit counter == FRAME_BITS and a valid frame was loaded: pop the FIFO.
  - Bit counter == FRAME_BITS and the loaded frame carried ovf = 1: clear overflow.
  - Bit counter < FRAME_BITS (aborted read): no pop, no overflow clear.
- Overflow set and clear in the same cycle: set wins.
- Push and pop in the same cycle: both occur; count is unchanged.
- LED:
  - Low solid while overflow is set.
  - Otherwise, while the FIFO is non-empty, toggles every 2^(LED_DIV_LOG2-3) cycles (fast blink).
  - Otherwise heartbeat toggle.

## Timing
- Reset values:
  - held, FIFO, pointers and overflow: 0.
  - sdo1_out: 0.
  - ready_n_ts_out: high-Z.
  - status_led_n_out: 1.
  - Heartbeat counter: 0; grant pointer: 0.
- found_in high at edge N: held set at N. Pushed at N+1 if granted. ready_n_ts_out driven low from edge N+2 (registered).
- SPI edge-to-action latency: 3 clk_in cycles (2 sync + 1 detect). sck1 high and low phases are each at least 4 clk_in cycles.
- Pop on cs1_n rising: 3 cycles after the pin edge. ready_n_ts_out releases one cycle after the pop that empties the FIFO, provided overflow is clear.
- Asserting reset_n_in mid-frame discards all state immediately. The next frame after release is built from an empty FIFO.

## Structure
- Shared package shapool_pkg holds:
  - the FRAME_BITS function;
  - header bit positions (HDR_VALID = 7, HDR_OVF = 6, HDR_IDX_MSB = 5);
  - the frame typedef.
- Sub-module sync_fifo: parametrised width and depth. Ports: push, pop, din, dout, full, empty. Same async active-low reset.
- Synchronisers, arbiter, shift register and LED counter are inline.

## Test plan
- POOL_SIZE = 2, found_in = 2'b01 with nonce 32'hDEADBEEF, then a 40-clock frame with sdi1 = 0 -> sdo1 carries 8'h80, 32'hDEADBEEF; ready_n_ts_out goes high-Z after cs1_n rises.
- Simultaneous found_in = 2'b11 with nonces 32'h11111111 and 32'h22222222 -> two frames read: pool 0 first (header 8'h80), then pool 1 (8'h81); no overflow.
- Fill the FIFO (4 entries) plus both holding registers, then pulse pool 0 again -> overflow set, LED solid low; drain 6 frames; the frame carrying ovf = 1 clears it.
- Daisy pass-through: FIFO empty, two frames clocked (80 sck) with sdi1 = upstream frame 8'h83, 32'hCAFEF00D -> sdo1 bits 40..79 equal that frame.
- Abort: cs1_n raised after 20 sck -> FIFO not popped; the next full frame returns the same nonce.
- Assert reset_n_in mid-frame with FIFO non-empty -> sdo1_out = 0, ready_n_ts_out high-Z, LED = 1, within the same cycle.

Source files
------------

// File: rtl/shapool_pkg.sv
// Shared definitions for the SHA-256 pool result path: frame length and header layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package shapool_pkg;

    localparam int HDR_VALID   = 7;
    localparam int HDR_OVF     = 6;
    localparam int HDR_IDX_MSB = 5;

    // Header byte leading every daisy frame; field order matches the bit positions above.
    typedef struct packed {
        logic                 valid;
        logic                 ovf;
        logic [HDR_IDX_MSB:0] idx;
    } hdr_t;

    // One header byte followed by the nonce.
    function automatic int frame_bits(input int nonce_width);
        return 8 + nonce_width;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO, 2^DEPTH_LOG2 entries of WIDTH bits, first-word fall-through head.
// Latency: push visible at dout/empty one cycle later.
// Backpressure: push ignored while full, pop ignored while empty; push and pop may coincide.
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;
    logic                do_push;
    logic                do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                     (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[DEPTH_LOG2-1:0]];

    // Storage and pointers; the extra pointer bit separates full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[DEPTH_LOG2-1:0]] <= din;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/pool_result_collector.sv
// Captures per-pool nonce hits, arbitrates them round-robin into a FIFO and serves them as daisy SPI frames.
// Latency: found to FIFO 1 cycle, ready line 2 cycles; SPI pin edges act 3 cycles after the pin moves.
// Backpressure: FIFO full stalls the arbiter, pools keep their holding register; a repeat hit on a held pool sets overflow.
module pool_result_collector
    import shapool_pkg::*;
#(
    parameter int POOL_SIZE       = 2,
    parameter int POOL_SIZE_LOG2  = 1,
    parameter int NONCE_WIDTH     = 32,
    parameter int FIFO_DEPTH_LOG2 = 2,
    parameter int LED_DIV_LOG2    = 22   // must be at least 3
) (
    input  logic                             clk_in,
    input  logic                             reset_n_in,
    input  logic [POOL_SIZE-1:0]             found_in,
    input  logic [POOL_SIZE*NONCE_WIDTH-1:0] nonce_in,
    input  logic                             sck1_in,
    input  logic                             sdi1_in,
    input  logic                             cs1_n_in,
    output logic                             sdo1_out,
    output logic                             ready_n_ts_out,
    output logic                             status_led_n_out
);

    localparam int FB = frame_bits(NONCE_WIDTH);
    localparam int IW = (POOL_SIZE_LOG2 > 0) ? POOL_SIZE_LOG2 : 1;
    localparam int EW = (HDR_IDX_MSB + 1) + NONCE_WIDTH;
    localparam int CW = $clog2(FB + 1);
    localparam logic [IW:0] POOL_W = (IW+1)'(POOL_SIZE);
    localparam logic [LED_DIV_LOG2-1:0] FAST_MASK =
        LED_DIV_LOG2'((64'd1 << (LED_DIV_LOG2 - 3)) - 64'd1);

    // Capture and arbitration state
    logic [POOL_SIZE-1:0]   held;
    logic [NONCE_WIDTH-1:0] hold_nonce [POOL_SIZE];
    logic [IW-1:0]          rr_ptr;
    logic                   overflow;
    logic [POOL_SIZE-1:0]   rotated;
    logic [IW:0]            gnt_off;
    logic [IW:0]            gnt_sum;
    logic [IW:0]            gnt_wrap;
    logic [IW:0]            nxt_sum;
    logic [IW-1:0]          gnt_idx;
    logic [IW-1:0]          nxt_ptr;
    logic                   gnt_vld;

    // FIFO interface
    logic                   fifo_push;
    logic                   fifo_pop;
    logic [EW-1:0]          fifo_din;
    logic [EW-1:0]          fifo_dout;
    logic                   fifo_full;
    logic                   fifo_empty;

    // SPI side
    logic [2:0]             sck_sync;
    logic [2:0]             cs_sync;
    logic [1:0]             sdi_sync;
    logic                   sck_rise;
    logic                   sck_fall;
    logic                   cs_fall;
    logic                   cs_rise;
    logic [FB-1:0]          shreg;
    logic [FB-1:0]          load_frame;
    hdr_t                   load_hdr;
    logic [CW-1:0]          bit_cnt;
    logic                   frame_valid;
    logic                   frame_ovf;
    logic                   frame_done;
    logic                   ready_drive;
    logic [LED_DIV_LOG2-1:0] hb_cnt;

    // Round-robin pick: rotate held[] so rr_ptr sits at bit 0, take the lowest set bit, rotate back.
    always_comb begin
        rotated = POOL_SIZE'({held, held} >> rr_ptr);
        gnt_vld = |held;
        gnt_off = '0;
        for (int k = POOL_SIZE - 1; k >= 0; k--) begin
            if (rotated[k]) gnt_off = (IW+1)'(k);
        end
        gnt_sum  = {1'b0, rr_ptr} + gnt_off;
        gnt_wrap = (gnt_sum >= POOL_W) ? (gnt_sum - POOL_W) : gnt_sum;
        gnt_idx  = IW'(gnt_wrap);
        nxt_sum  = gnt_wrap + 1'b1;
        nxt_ptr  = IW'((nxt_sum >= POOL_W) ? (nxt_sum - POOL_W) : nxt_sum);
    end

    assign fifo_push = gnt_vld && !fifo_full;
    assign fifo_din  = {(HDR_IDX_MSB+1)'(gnt_idx), hold_nonce[gnt_idx]};

    // Holding registers: first hit wins, a repeat hit while held is dropped; grant frees the slot.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            held   <= '0;
            rr_ptr <= '0;
            for (int i = 0; i < POOL_SIZE; i++) hold_nonce[i] <= '0;
        end else begin
            for (int i = 0; i < POOL_SIZE; i++) begin
                if (found_in[i] && !held[i]) begin
                    held[i]       <= 1'b1;
                    hold_nonce[i] <= nonce_in[i*NONCE_WIDTH +: NONCE_WIDTH];
                end else if (fifo_push && gnt_idx == IW'(i)) begin
                    held[i] <= 1'b0;
                end
            end
            if (fifo_push) rr_ptr <= nxt_ptr;
        end
    end

    sync_fifo #(
        .WIDTH      (EW),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk_in),
        .rst_n (reset_n_in),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Two-stage synchronisers plus one delay stage for edge detection; cs idles high.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            sck_sync <= 3'b000;
            cs_sync  <= 3'b111;
            sdi_sync <= 2'b00;
        end else begin
            sck_sync <= {sck_sync[1:0], sck1_in};
            cs_sync  <= {cs_sync[1:0], cs1_n_in};
            sdi_sync <= {sdi_sync[0], sdi1_in};
        end
    end

    assign sck_rise   = sck_sync[1] && !sck_sync[2];
    assign sck_fall   = !sck_sync[1] && sck_sync[2];
    assign cs_fall    = !cs_sync[1] && cs_sync[2];
    assign cs_rise    = cs_sync[1] && !cs_sync[2];
    assign frame_done = (bit_cnt == CW'(FB));
    assign fifo_pop   = cs_rise && frame_done && frame_valid;

    // Frame to load on select: FIFO head if any, otherwise an invalid frame still reporting overflow.
    always_comb begin
        load_hdr.valid = !fifo_empty;
        load_hdr.ovf   = overflow;
        load_hdr.idx   = fifo_empty ? '0 : fifo_dout[EW-1 -: (HDR_IDX_MSB+1)];
        load_frame     = {load_hdr, (fifo_empty ? {NONCE_WIDTH{1'b0}} : fifo_dout[NONCE_WIDTH-1:0])};
    end

    // Mode-0 shift register: load on select, shift in on sck rise, present MSB on sck fall.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            shreg       <= '0;
            bit_cnt     <= '0;
            sdo1_out    <= 1'b0;
            frame_valid <= 1'b0;
            frame_ovf   <= 1'b0;
        end else if (cs_fall) begin
            shreg       <= load_frame;
            bit_cnt     <= '0;
            sdo1_out    <= load_frame[FB-1];
            frame_valid <= load_hdr.valid;
            frame_ovf   <= load_hdr.ovf;
        end else if (!cs_sync[1]) begin
            if (sck_rise) begin
                shreg <= {shreg[FB-2:0], sdi_sync[1]};
                if (!frame_done) bit_cnt <= bit_cnt + 1'b1;
            end
            if (sck_fall) sdo1_out <= shreg[FB-1];
        end
    end

    // Sticky overflow: a new drop outranks a clear from a completed read.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            overflow <= 1'b0;
        end else if (|(found_in & held)) begin
            overflow <= 1'b1;
        end else if (cs_rise && frame_done && frame_ovf) begin
            overflow <= 1'b0;
        end
    end

    // Registered open-drain request: pull low while anything is pending.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) ready_drive <= 1'b0;
        else             ready_drive <= !fifo_empty || overflow;
    end

    assign ready_n_ts_out = ready_drive ? 1'b0 : 1'bz;

    // Status LED: solid on overflow, fast blink with results pending, slow heartbeat otherwise.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            hb_cnt           <= '0;
            status_led_n_out <= 1'b1;
        end else begin
            hb_cnt <= hb_cnt + 1'b1;
            if (overflow)
                status_led_n_out <= 1'b0;
            else if (!fifo_empty) begin
                if ((hb_cnt & FAST_MASK) == FAST_MASK) status_led_n_out <= !status_led_n_out;
            end else if (&hb_cnt)
                status_led_n_out <= !status_led_n_out;
        end
    end

endmodule

// File: tb/tb_pool_result_collector.sv
// Directed bench for pool_result_collector: table of single-pulse vectors plus hand-written corner sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_pool_result_collector;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  found;
    logic [63:0] nonce;
    logic        sck;
    logic        sdi;
    logic        cs_n;
    logic        sdo;
    wire         ready_n;
    logic        led_n;

    int checks = 0;
    int failures = 0;

    pullup (ready_n);

    always #5 clk = ~clk;

    pool_result_collector #(
        .POOL_SIZE       (2),
        .POOL_SIZE_LOG2  (1),
        .NONCE_WIDTH     (32),
        .FIFO_DEPTH_LOG2 (2),
        .LED_DIV_LOG2    (6)
    ) dut (
        .clk_in           (clk),
        .reset_n_in       (reset_n),
        .found_in         (found),
        .nonce_in         (nonce),
        .sck1_in          (sck),
        .sdi1_in          (sdi),
        .cs1_n_in         (cs_n),
        .sdo1_out         (sdo),
        .ready_n_ts_out   (ready_n),
        .status_led_n_out (led_n)
    );

    typedef struct {
        logic [1:0]  found;
        logic [31:0] n0;
        logic [31:0] n1;
        int          nfr;
        logic [7:0]  hdr0;
        logic [31:0] non0;
        logic [7:0]  hdr1;
        logic [31:0] non1;
    } vec_t;

    vec_t        vecs [3];
    logic [7:0]  drain_hdr [6];
    logic [31:0] drain_non [6];
    logic [127:0] got;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        found   = '0;
        nonce   = '0;
        sck     = 1'b0;
        sdi     = 1'b0;
        cs_n    = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse(input logic [1:0] f, input logic [31:0] n0, input logic [31:0] n1);
        found = f;
        nonce = {n1, n0};
        @(negedge clk);
        found = '0;
    endtask

    // Full SPI transaction of nsck clocks; up[nsck-1] is sent first, got[nsck-1] is the first bit seen.
    task automatic spi_xfer(input int nsck, input logic [127:0] up, output logic [127:0] rx);
        rx   = '0;
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int b = nsck - 1; b >= 0; b--) begin
            sdi = up[7'(b)];
            repeat (8) @(negedge clk);
            rx[7'(b)] = sdo;
            sck = 1'b1;
            repeat (8) @(negedge clk);
            sck = 1'b0;
        end
        repeat (8) @(negedge clk);
        cs_n = 1'b1;
        sdi  = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{2'b01, 32'hDEADBEEF, 32'h0,        1, 8'h80, 32'hDEADBEEF, 8'h00, 32'h0};
        vecs[1] = '{2'b11, 32'h11111111, 32'h22222222, 2, 8'h80, 32'h11111111, 8'h81, 32'h22222222};
        vecs[2] = '{2'b10, 32'h0,        32'h5A5AA5A5, 1, 8'h81, 32'h5A5AA5A5, 8'h00, 32'h0};

        drain_hdr = '{8'hC0, 8'h81, 8'h80, 8'h81, 8'h80, 8'h81};
        drain_non = '{32'hA0000000, 32'hB0000001, 32'hC0000002, 32'hD0000003, 32'hE0000004, 32'hF0000005};

        // Reset state and heartbeat
        do_reset();
        check("rst_sdo", sdo, 1'b0);
        check("rst_ready", ready_n, 1'b1);
        check("rst_led", led_n, 1'b1);
        repeat (10) @(negedge clk);
        check("hb_before_toggle", led_n, 1'b1);
        repeat (60) @(negedge clk);
        check("hb_after_toggle", led_n, 1'b0);

        // Table-driven capture and readout
        for (int v = 0; v < 3; v++) begin
            do_reset();
            check($sformatf("v%0d_rst_ready", v), ready_n, 1'b1);
            check($sformatf("v%0d_rst_sdo", v), sdo, 1'b0);
            found = vecs[v].found;
            nonce = {vecs[v].n1, vecs[v].n0};
            @(negedge clk);
            found = '0;
            @(negedge clk);
            check($sformatf("v%0d_ready_n1", v), ready_n, 1'b1);
            @(negedge clk);
            check($sformatf("v%0d_ready_n2", v), ready_n, 1'b0);
            for (int f = 0; f < vecs[v].nfr; f++) begin
                spi_xfer(40, '0, got);
                check($sformatf("v%0d_f%0d_hdr", v, f), got[39:32], (f == 0) ? vecs[v].hdr0 : vecs[v].hdr1);
                check($sformatf("v%0d_f%0d_nonce", v, f), got[31:0], (f == 0) ? vecs[v].non0 : vecs[v].non1);
            end
            check($sformatf("v%0d_ready_released", v), ready_n, 1'b1);
        end

        // Fill FIFO and both holding registers, then force an overflow
        do_reset();
        pulse(2'b11, 32'hA0000000, 32'hB0000001);
        repeat (4) @(negedge clk);
        pulse(2'b11, 32'hC0000002, 32'hD0000003);
        repeat (4) @(negedge clk);
        pulse(2'b11, 32'hE0000004, 32'hF0000005);
        repeat (4) @(negedge clk);
        pulse(2'b01, 32'h99999999, 32'h0);
        repeat (4) @(negedge clk);
        check("ovf_led_solid", led_n, 1'b0);
        check("ovf_ready", ready_n, 1'b0);
        repeat (20) @(negedge clk);
        check("ovf_led_still_solid", led_n, 1'b0);
        for (int f = 0; f < 6; f++) begin
            spi_xfer(40, '0, got);
            check($sformatf("drain%0d_hdr", f), got[39:32], drain_hdr[f]);
            check($sformatf("drain%0d_nonce", f), got[31:0], drain_non[f]);
        end
        check("drain_ready_released", ready_n, 1'b1);

        // Daisy pass-through with an empty FIFO
        do_reset();
        spi_xfer(80, {48'h0, 8'h83, 32'hCAFEF00D, 40'h0}, got);
        check("daisy_own_frame", got[79:40], 40'h0);
        check("daisy_upstream", got[39:0], {8'h83, 32'hCAFEF00D});
        check("daisy_ready", ready_n, 1'b1);

        // Aborted read leaves the FIFO intact
        do_reset();
        pulse(2'b10, 32'h0, 32'h13579BDF);
        repeat (4) @(negedge clk);
        spi_xfer(20, '0, got);
        check("abort_hdr", got[19:12], 8'h81);
        check("abort_partial", got[11:0], 12'h135);
        check("abort_no_pop_ready", ready_n, 1'b0);
        spi_xfer(40, '0, got);
        check("abort_retry_hdr", got[39:32], 8'h81);
        check("abort_retry_nonce", got[31:0], 32'h13579BDF);
        check("abort_retry_ready", ready_n, 1'b1);

        // Reset asserted mid-frame with a pending result
        do_reset();
        pulse(2'b01, 32'h89ABCDEF, 32'h0);
        repeat (4) @(negedge clk);
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
        check("mid_sdo_msb", sdo, 1'b1);
        check("mid_ready", ready_n, 1'b0);
        reset_n = 1'b0;
        cs_n    = 1'b1;
        #1;
        check("mid_rst_sdo", sdo, 1'b0);
        check("mid_rst_ready", ready_n, 1'b1);
        check("mid_rst_led", led_n, 1'b1);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_ready", ready_n, 1'b1);
        spi_xfer(40, '0, got);
        check("post_rst_frame", got[39:0], 40'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
